sequential_subtractor_64bit: RTL and testbench

- Multi-cycle borrow-chain subtractor: D = A - B - Bi over WIDTH bits.
- Computes one SLICE-bit segment per clock using a single FullAdder4Bit-style slice, fed A, ~B and an inverted borrow.
- Companion to the combinational adder path; used where area matters more than latency.
- Valid/ready handshake on both input and output sides.

---
 rtl/sequential_subtractor_64bit.sv | 176 +++++++++++++++++
 tb/tb_sequential_subtractor_64bit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sequential_subtractor_64bit.sv
// Multi-cycle borrow-chain subtractor: D = A - B - Bi, one SLICE-bit segment per clock.
// Optional macro SUB_OVERFLOW_FLAG_EN adds a registered signed-overflow output V.
module sequential_subtractor_64bit #(
    parameter int WIDTH = 64,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             busy
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    output logic             V
`endif
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("WIDTH must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bo_q, bo_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               v_q, v_d;
`endif

    logic [SLICE:0]     slice_sum;
    logic [WIDTH-1:0]   res_next;

    // The single slice adder: A + ~B + carry, where carry starts as ~Bi.
    assign slice_sum = (SLICE+1)'(a_q[SLICE-1:0]) + (SLICE+1)'(nb_q[SLICE-1:0])
                     + (SLICE+1)'(carry_q);
    // New segment enters at the top; after N steps segment 0 lands in the low bits.
    assign res_next  = (res_q >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path can leave a latch behind.
        state_d     = state_q;
        a_d         = a_q;
        nb_d        = nb_q;
        res_d       = res_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        d_d         = d_q;
        bo_d        = bo_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef SUB_OVERFLOW_FLAG_EN
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        v_d         = v_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d        = A;
                    nb_d       = ~B;
                    carry_d    = ~Bi;
                    idx_d      = '0;
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef SUB_OVERFLOW_FLAG_EN
                    a_msb_d    = A[WIDTH-1];
                    b_msb_d    = B[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                a_d     = a_q >> SLICE;
                nb_d    = nb_q >> SLICE;
                res_d   = res_next;
                carry_d = slice_sum[SLICE];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_d       = '0;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    d_d         = res_next;
                    bo_d        = ~slice_sum[SLICE];
`ifdef SUB_OVERFLOW_FLAG_EN
                    v_d         = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            res_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            d_q         <= '0;
            bo_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            v_q         <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            nb_q        <= nb_d;
            res_q       <= res_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            d_q         <= d_d;
            bo_q        <= bo_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SUB_OVERFLOW_FLAG_EN
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            v_q         <= v_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign D         = d_q;
    assign Bo        = bo_q;
`ifdef SUB_OVERFLOW_FLAG_EN
    assign V         = v_q;
`endif

endmodule

// File: tb/tb_sequential_subtractor_64bit.sv
// Self-checking bench for sequential_subtractor_64bit: vector table, scoreboard queue,
// backpressure, early out_ready and mid-operation reset sequences.
module tb_sequential_subtractor_64bit;

    localparam int W = 64;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A_i, B_i;
    logic         Bi_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         Bo;
    logic         busy;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic         V;
`endif

    sequential_subtractor_64bit #(.WIDTH(W), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A_i),
        .B         (B_i),
        .Bi        (Bi_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bo        (Bo),
        .busy      (busy)
`ifdef SUB_OVERFLOW_FLAG_EN
        ,
        .V         (V)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] d;
        logic         bo;
        logic         v;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         v;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input logic [W-1:0] ed, input logic ebo, input logic ev,
                         input int hold, input bit early);
        int           n;
        logic [W-1:0] d0;
        logic         bo0;
        bit           stable;
        exp_t         e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_idle", W'(in_ready), W'(1));
        A_i = a; B_i = b; Bi_i = bi; in_valid = 1'b1; out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back('{d: ed, bo: ebo, v: ev});
        check("in_ready_run", W'(in_ready), W'(0));
        check("busy_run", W'(busy), W'(1));
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("latency", W'(n), W'(N));
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty: got result %h expected none", D);
            end else begin
                e = sb_q.pop_front();
                check("result_D", D, e.d);
                check("result_Bo", W'(Bo), W'(e.bo));
`ifdef SUB_OVERFLOW_FLAG_EN
                check("result_V", W'(V), W'(e.v));
`endif
            end
        end
        if (!early) begin
            d0 = D; bo0 = Bo; stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                A_i = ~a; B_i = a; in_valid = 1'b1;
                @(posedge clk); #1;
                if (!out_valid || D !== d0 || Bo !== bo0 || in_ready || !busy) stable = 1'b0;
            end
            in_valid = 1'b0;
            if (hold > 0) check("hold_stable", W'(stable), W'(1));
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", W'(out_valid), W'(0));
        check("in_ready_after", W'(in_ready), W'(1));
        check("busy_after", W'(busy), W'(0));
    endtask

    initial begin
        vec_t         vecs[7];
        logic [W:0]   m;
        logic [W-1:0] ra, rb;
        logic         rbi;
        bit           seen;
        int           n;

        vecs[0] = '{a: 64'd5, b: 64'd3, bi: 1'b0, d: 64'd2, bo: 1'b0, v: 1'b0};
        vecs[1] = '{a: 64'd0, b: 64'd1, bi: 1'b0, d: '1, bo: 1'b1, v: 1'b0};
        vecs[2] = '{a: '1, b: '1, bi: 1'b1, d: '1, bo: 1'b1, v: 1'b0};
        vecs[3] = '{a: 64'h10, b: 64'h0F, bi: 1'b1, d: 64'd0, bo: 1'b0, v: 1'b0};
        vecs[4] = '{a: 64'd0, b: 64'd0, bi: 1'b1, d: '1, bo: 1'b1, v: 1'b0};
        vecs[5] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, bi: 1'b0,
                    d: 64'h7FFF_FFFF_FFFF_FFFF, bo: 1'b0, v: 1'b1};
        vecs[6] = '{a: 64'd9, b: 64'd4, bi: 1'b0, d: 64'd5, bo: 1'b0, v: 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A_i = '0; B_i = '0; Bi_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_busy", W'(busy), W'(0));
        check("reset_D", D, W'(0));
        check("reset_Bo", W'(Bo), W'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo, vecs[i].v,
                  (i == 1) ? 20 : (i % 2), i == 3);

        for (int i = 0; i < 4; i++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rbi = 1'($urandom_range(0, 1));
            m   = {1'b0, ra} - {1'b0, rb} - (W+1)'(rbi);
            do_op(ra, rb, rbi, m[W-1:0], m[W], (ra[W-1] != rb[W-1]) && (m[W-1] != ra[W-1]),
                  i, 1'b0);
        end

        // Reset during RUN: the pending operation must vanish without a result.
        A_i = 64'd100; B_i = 64'd1; Bi_i = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midrun_reset_out_valid", W'(out_valid), W'(0));
        check("midrun_reset_in_ready", W'(in_ready), W'(1));
        check("midrun_reset_busy", W'(busy), W'(0));
        check("midrun_reset_D", D, W'(0));
        check("midrun_reset_Bo", W'(Bo), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("no_result_after_reset", W'(seen), W'(0));
        do_op(vecs[6].a, vecs[6].b, vecs[6].bi, vecs[6].d, vecs[6].bo, vecs[6].v, 0, 1'b0);

        check("scoreboard_drained", W'(sb_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
